// File: rtl/elastic_pipe_reg_pkg.sv
// Shared constants for the MIPS inter-stage pipeline register: depth limit, field widths and
// control-bit positions within the {WB_en, MEM_R_EN, MEM_W_EN} control field.
package elastic_pipe_reg_pkg;

    localparam int unsigned PIPE_MAX_DEPTH = 4;
    localparam int unsigned CTRL_W_MIPS    = 3;
    localparam int unsigned DATA_W_MIPS    = 68;

    localparam int unsigned CTRL_WB = 2;
    localparam int unsigned CTRL_MR = 1;
    localparam int unsigned CTRL_MW = 0;

    typedef logic [CTRL_W_MIPS-1:0] mips_ctrl_t;

    function automatic mips_ctrl_t mips_ctrl(input logic wb, input logic mr, input logic mw);
        mips_ctrl_t c;
        c          = '0;
        c[CTRL_WB] = wb;
        c[CTRL_MR] = mr;
        c[CTRL_MW] = mw;
        return c;
    endfunction

endpackage

// File: rtl/elastic_pipe_reg_pipe_stage.sv
// One slice of the elastic pipeline register: valid bit, control field (zeroed when empty)
// and payload (held when the stage empties).
module elastic_pipe_reg_pipe_stage
    import elastic_pipe_reg_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_MIPS,
    parameter int unsigned DATA_W = DATA_W_MIPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              vacate,
    input  logic              kill,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    logic              valid_d, valid_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic [DATA_W-1:0] data_d, data_q;

    // Kill wins over load and hold alike; the payload is still captured on a killed load.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            ctrl_d  = d_ctrl;
            data_d  = d_data;
        end else if (vacate) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
        if (kill) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign q_valid = valid_q;
    assign q_ctrl  = ctrl_q;
    assign q_data  = data_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic DEPTH-stage pipeline register between two MIPS stages with valid/ready flow control,
// bubble collapse, global freeze and per-stage flush.
module elastic_pipe_reg
    import elastic_pipe_reg_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CTRL_W = CTRL_W_MIPS,
    parameter int unsigned DATA_W = DATA_W_MIPS,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic [DEPTH-1:0]  flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy
);

    if (DEPTH < 1 || DEPTH > PIPE_MAX_DEPTH) begin : g_bad_depth
        $error("elastic_pipe_reg: DEPTH out of range");
    end

    logic [DEPTH-1:0]  v;
    logic [DEPTH-1:0]  adv;
    logic [DEPTH-1:0]  load;
    logic [CTRL_W-1:0] s_ctrl [DEPTH];
    logic [DATA_W-1:0] s_data [DEPTH];
    logic              room;

    // Walk from the output back to stage 0; room means "the slot ahead is free or freeing".
    always_comb begin
        adv  = '0;
        room = out_ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            adv[i] = v[i] & room & ~freeze;
            room   = ~v[i] | adv[i];
        end
        in_ready = ~freeze & room;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [CTRL_W-1:0] src_ctrl;
        logic [DATA_W-1:0] src_data;

        if (i == 0) begin : g_head
            assign load[i]  = in_valid & in_ready;
            assign src_ctrl = in_ctrl;
            assign src_data = in_data;
        end else begin : g_body
            assign load[i]  = adv[i-1];
            assign src_ctrl = s_ctrl[i-1];
            assign src_data = s_data[i-1];
        end

        elastic_pipe_reg_pipe_stage #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .load    (load[i]),
            .vacate  (adv[i]),
            .kill    (flush[i]),
            .d_ctrl  (src_ctrl),
            .d_data  (src_data),
            .q_valid (v[i]),
            .q_ctrl  (s_ctrl[i]),
            .q_data  (s_data[i])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occupancy = occupancy + CNT_W'(v[i]);
        end
    end

    assign out_valid = v[DEPTH-1] & ~freeze;
    assign out_ctrl  = out_valid ? s_ctrl[DEPTH-1] : '0;
    assign out_data  = s_data[DEPTH-1];

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Randomised and directed bench for elastic_pipe_reg, checked against a queue-of-items model
// where each in-flight item carries its stage position.
module tb_elastic_pipe_reg;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned DATA_W = 68;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              freeze;
    logic [DEPTH-1:0]  flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  occupancy;

    elastic_pipe_reg #(
        .DEPTH  (DEPTH),
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .freeze    (freeze),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Model: in-flight items, oldest first, each with its stage index.
    int                m_pos  [$];
    logic [CTRL_W-1:0] m_ctrl [$];
    logic [DATA_W-1:0] m_data [$];
    // Last-stage payload register, which holds after the item leaves.
    bit                ld_known = 1'b0;
    logic [DATA_W-1:0] ld_val;
    bit                last_acc;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic f, input logic [DEPTH-1:0] fl, input logic v,
                         input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d, input logic o);
        bit mv [$];
        int n;
        bit exp_rdy, front_out, acc, m;
        rst = r; freeze = f; flush = fl; in_valid = v; in_ctrl = c; in_data = d; out_ready = o;
        @(negedge clk);
        n = m_pos.size();
        for (int k = 0; k < n; k++) begin
            if (f) m = 1'b0;
            else if (k == 0) m = (m_pos[0] == DEPTH - 1) ? o : 1'b1;
            else m = (m_pos[k-1] > m_pos[k] + 1) || mv[k-1];
            mv.push_back(m);
        end
        front_out = (n > 0) && (m_pos[0] == DEPTH - 1);
        exp_rdy   = !f && (n == 0 || m_pos[n-1] > 0 || mv[n-1]);
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("out_valid", out_valid, !f && front_out);
        check_eq("out_ctrl", out_ctrl, (!f && front_out) ? m_ctrl[0] : '0);
        if (front_out) check_eq("out_data", out_data, m_data[0]);
        else if (ld_known) check_eq("out_data_held", out_data, ld_val);
        check_eq("occupancy", occupancy, n);
        acc = v && exp_rdy;
        @(posedge clk);
        last_acc = acc && !r;
        if (r) begin
            m_pos.delete(); m_ctrl.delete(); m_data.delete();
            ld_known = 1'b1;
            ld_val   = '0;
        end else begin
            for (int k = 0; k < n; k++) begin
                if (mv[k]) begin
                    m_pos[k]++;
                    if (m_pos[k] == DEPTH - 1) begin
                        ld_known = !fl[DEPTH-1];
                        ld_val   = m_data[k];
                    end
                end
            end
            if (n > 0 && m_pos[0] == DEPTH) begin
                void'(m_pos.pop_front()); void'(m_ctrl.pop_front()); void'(m_data.pop_front());
            end
            if (acc) begin
                m_pos.push_back(0); m_ctrl.push_back(c); m_data.push_back(d);
                if (DEPTH == 1) begin
                    ld_known = !fl[0];
                    ld_val   = d;
                end
            end
            for (int k = m_pos.size() - 1; k >= 0; k--) begin
                if (fl[m_pos[k]]) begin
                    m_pos.delete(k); m_ctrl.delete(k); m_data.delete(k);
                end
            end
        end
        #1;
    endtask

    function automatic logic [DATA_W-1:0] item(input int i);
        return {4'hA, 32'hDEAD_0000 + 32'(i), 32'(i) * 32'h0101_0101};
    endfunction

    task automatic idle(input int cycles, input logic o);
        for (int i = 0; i < cycles; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, o);
    endtask

    // Offer items first..first+count-1 in order; out_ready goes high at cycle ready_at.
    task automatic stream(input int first, input int count, input int cycles, input int ready_at);
        int idx = 0;
        for (int t = 0; t < cycles; t++) begin
            cycle(1'b0, 1'b0, '0, idx < count, CTRL_W'(first + idx), item(first + idx),
                  t >= ready_at);
            if (last_acc) idx++;
        end
    endtask

    logic [DATA_W-1:0] rnd_data;

    initial begin
        // 1: reset, then single item with out_ready=1
        cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1, 3'b101, item(1), 1'b1);
        idle(3, 1'b1);
        // 2: back-to-back stream stalled from cycle 2, then drained
        stream(10, 4, 12, 6);
        // 3: bubble collapse while stalled
        cycle(1'b0, 1'b0, '0, 1'b1, 3'b100, item(20), 1'b0);
        idle(1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 3'b010, item(21), 1'b0);
        idle(2, 1'b0);
        // 4: freeze a full pipe for 3 cycles, then release
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0, 1'b1, 3'b111, item(22), 1'b1);
        stream(22, 2, 6, 0);
        // 5: flush on accept, and flush of a stalled output item
        cycle(1'b0, 1'b0, 2'b01, 1'b1, 3'b101, item(30), 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 3'b110, item(31), 1'b0);
        idle(1, 1'b0);
        cycle(1'b0, 1'b0, 2'b10, 1'b0, '0, '0, 1'b0);
        idle(2, 1'b1);
        // 6: reset mid-stream while frozen
        stream(40, 3, 3, 9);
        cycle(1'b1, 1'b1, '0, 1'b1, 3'b001, item(43), 1'b1);
        cycle(1'b0, 1'b1, '0, 1'b0, '0, '0, 1'b1);
        idle(2, 1'b1);
        // Random traffic
        for (int t = 0; t < 4000; t++) begin
            rnd_data = {$urandom, $urandom, $urandom};
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                  {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0},
                  $urandom_range(0, 2) != 0, CTRL_W'($urandom), rnd_data,
                  $urandom_range(0, 2) != 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
